// File: rtl/gate_truth_table_checker_if.sv
// Signal bundle between a gate truth-table checker (slave) and its gate/controller side (master).
// Checker drives the vector and status; the other side drives start and the gate output.
interface gate_truth_table_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
  );

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps all 2^N_IN vectors into a gate, holding each SETTLE+1 cycles; done 2^N_IN*(SETTLE+1)+1 cycles after start.
// No backpressure: start is taken only in IDLE and ignored while busy; all outputs are registered.
module gate_truth_table_checker #(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1110
) (
  input  logic                       clk,
  input  logic                       rst,
  gate_truth_table_checker_if.slave  bus
);

  localparam int                CW       = (SETTLE <= 1) ? 1 : $clog2(SETTLE);
  localparam logic [CW-1:0]     CNT_INIT = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   VEC_LAST = N_IN'((1 << N_IN) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   fail_cnt_q;
  logic [N_IN-1:0] ff_vec_q;
  logic            ff_vld_q;

  logic            mismatch_d;
  logic [N_IN:0]   fail_cnt_d;

  // The gate output is only looked at in CHECK, so settling glitches never count.
  always_comb begin
    mismatch_d = 1'b0;
    if (state_q == S_CHECK) begin
      mismatch_d = (bus.dut_out != EXPECT[vec_q]);
    end
    fail_cnt_d = fail_cnt_q + {{N_IN{1'b0}}, mismatch_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            vec_q      <= '0;
            cnt_q      <= CNT_INIT;
            fail_cnt_q <= '0;
            ff_vec_q   <= '0;
            ff_vld_q   <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_CHECK: begin
          fail_cnt_q <= fail_cnt_d;
          if (mismatch_d && !ff_vld_q) begin
            ff_vec_q <= vec_q;
            ff_vld_q <= 1'b1;
          end
          // pass is registered here so it is already valid alongside the done pulse.
          if (vec_q == VEC_LAST) begin
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + N_IN'(1);
            cnt_q   <= CNT_INIT;
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          vec_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in           = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fail_cnt_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign bus.first_fail_valid = ff_vld_q;

endmodule
